// File: rtl/rr_mux_reg_pkg.sv
// Shared helpers for the round-robin mux family: source-index width function,
// default sizes, the per-cycle output action and the N >= 2 elaboration check.
`ifndef RR_MUX_REG_PKG_SV
`define RR_MUX_REG_PKG_SV

// A mux with fewer than two channels has nothing to arbitrate.
`define MUX_CHECK_N(n) if ((n) < 2) begin : g_bad_n $error("rr mux: N must be >= 2"); end

package rr_mux_reg_pkg;

    localparam int DefaultWidth = 8;
    localparam int DefaultN     = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_DRAIN
    } out_action_e;

endpackage

`endif

// File: rtl/rr_mux_reg_if.sv
// Bundle of the N valid/ready source channels and the single valid/ready sink.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface rr_mux_reg_if import rr_mux_reg_pkg::*; #(
    parameter int WIDTH = DefaultWidth,
    parameter int N     = DefaultN
);
    localparam int SW = clog2(N);

    logic [N*WIDTH-1:0] inData;
    logic [N-1:0]       inValid;
    logic [N-1:0]       inReady;
    logic [WIDTH-1:0]   outData;
    logic [SW-1:0]      outSrc;
    logic               outValid;
    logic               outReady;

    modport master (
        output inData,
        output inValid,
        output outReady,
        input  inReady,
        input  outData,
        input  outSrc,
        input  outValid
    );

    modport slave (
        input  inData,
        input  inValid,
        input  outReady,
        output inReady,
        output outData,
        output outSrc,
        output outValid
    );

endinterface

// File: rtl/rr_mux_reg_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping to 0.
// Written as plain AND/OR arithmetic so unknown request bits propagate to the grant.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] g_o,
    output logic          any_o
);

    logic [N-1:0]   mask;
    logic [N-1:0]   folded;
    logic [2*N-1:0] doubled;
    logic [2*N-1:0] lowest;

    // Lower half holds only requests at or above ptr; upper half is the wrapped copy.
    assign mask    = {N{1'b1}} << ptr_i;
    assign doubled = {req_i, req_i & mask};
    assign lowest  = doubled & (~doubled + {{(2*N-1){1'b0}}, 1'b1});
    assign folded  = lowest[N-1:0] | lowest[2*N-1:N];
    assign any_o   = |req_i;

    always_comb begin
        g_o = '0;
        for (int i = 0; i < N; i++) begin
            g_o = g_o | ({SW{folded[i]}} & SW'(i));
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel round-robin multiplexer with a single registered output slot.
// Holds the only state: the priority pointer and the output beat register.
module rr_mux_reg import rr_mux_reg_pkg::*; #(
    parameter int WIDTH = DefaultWidth,
    parameter int N     = DefaultN
) (
    input logic         clk_i,
    input logic         rst_i,
    rr_mux_reg_if.slave bus
);

    localparam int SW = clog2(N);

    `MUX_CHECK_N(N)

    logic [SW-1:0]    ptr_q;
    logic [SW-1:0]    ptr_d;
    logic [WIDTH-1:0] outData_q;
    logic [WIDTH-1:0] outData_d;
    logic [SW-1:0]    outSrc_q;
    logic [SW-1:0]    outSrc_d;
    logic             outValid_q;
    logic             outValid_d;

    logic [SW-1:0]    grant;
    logic [SW-1:0]    ptrNext;
    logic             anyReq;
    logic             load;
    logic             drain;
    logic [N-1:0]     grantOneHot;
    logic [WIDTH-1:0] selData;
    out_action_e      action;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req_i (bus.inValid),
        .ptr_i (ptr_q),
        .g_o   (grant),
        .any_o (anyReq)
    );

    assign load  = (~outValid_q | bus.outReady) & anyReq & ~rst_i;
    assign drain = outValid_q & bus.outReady & ~anyReq;

    always_comb begin
        grantOneHot = '0;
        selData     = '0;
        for (int i = 0; i < N; i++) begin
            grantOneHot[i] = (grant == SW'(i));
        end
        for (int i = 0; i < N; i++) begin
            selData = selData | ({WIDTH{grantOneHot[i]}} & bus.inData[i*WIDTH +: WIDTH]);
        end
    end

    // Explicit wrap so non-power-of-two N never lets the pointer reach N.
    assign ptrNext = (grant == SW'(N-1)) ? '0 : grant + SW'(1);

    // Ternaries rather than if/case keep an unknown load visible in the next state.
    always_comb begin
        action     = load ? ACT_LOAD : (drain ? ACT_DRAIN : ACT_HOLD);
        outData_d  = (action == ACT_LOAD) ? selData : outData_q;
        outSrc_d   = (action == ACT_LOAD) ? grant   : outSrc_q;
        ptr_d      = (action == ACT_LOAD) ? ptrNext : ptr_q;
        outValid_d = (action == ACT_LOAD)  ? 1'b1 :
                     (action == ACT_DRAIN) ? 1'b0 : outValid_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            outData_q  <= '0;
            outSrc_q   <= '0;
            outValid_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
            outValid_q <= outValid_d;
        end
    end

    assign bus.inReady  = {N{load}} & grantOneHot;
    assign bus.outData  = outData_q;
    assign bus.outSrc   = outSrc_q;
    assign bus.outValid = outValid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: directed scenarios then random traffic on a 4-channel and
// a 3-channel instance, each compared every cycle against a priority-list model.
module tb_rr_mux_reg;
    import rr_mux_reg_pkg::*;

    typedef struct packed {
        int         ptr;
        bit         valid;
        logic [7:0] data;
        int         src;
    } model_t;

    logic clk = 1'b0;
    logic rst;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    model_t     mA, mB, nA, nB;
    logic [7:0] rExpA, rExpB;
    logic [7:0] lastA, lastB;

    rr_mux_reg_if #(.WIDTH(8), .N(4)) busA ();
    rr_mux_reg_if #(.WIDTH(8), .N(3)) busB ();

    rr_mux_reg #(.WIDTH(8), .N(4)) dutA (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busA)
    );

    rr_mux_reg #(.WIDTH(8), .N(3)) dutB (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan the priority list ptr, ptr+1, ... mod n for the first requester.
    task automatic modelEval(input model_t m, input int n, input logic r,
                             input logic [7:0] valid, input logic [31:0] flat,
                             input logic rdy, output model_t nxt,
                             output logic [7:0] readyExp);
        int g;
        nxt      = m;
        readyExp = '0;
        g        = -1;
        if (r) begin
            nxt = '0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = (m.ptr + k) % n;
            if (g < 0 && valid[c]) g = c;
        end
        if ((!m.valid || rdy) && g >= 0) begin
            readyExp[g] = 1'b1;
            nxt.valid   = 1'b1;
            nxt.data    = flat[g*8 +: 8];
            nxt.src     = g;
            nxt.ptr     = (g + 1) % n;
        end else if (m.valid && rdy && g < 0) begin
            nxt.valid = 1'b0;
        end
    endtask

    task automatic checkOutput();
        check("A_ready", 32'(busA.inReady),  32'(rExpA[3:0]));
        check("A_valid", 32'(busA.outValid), 32'(mA.valid));
        check("A_data",  32'(busA.outData),  32'(mA.data));
        check("A_src",   32'(busA.outSrc),   32'(mA.src));
        check("B_ready", 32'(busB.inReady),  32'(rExpB[2:0]));
        check("B_valid", 32'(busB.outValid), 32'(mB.valid));
        check("B_data",  32'(busB.outData),  32'(mB.data));
        check("B_src",   32'(busB.outSrc),   32'(mB.src));
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        modelEval(mA, 4, rst, 8'(busA.inValid), 32'(busA.inData), busA.outReady, nA, rExpA);
        modelEval(mB, 3, rst, 8'(busB.inValid), 32'(busB.inData), busB.outReady, nB, rExpB);
        checkOutput();
        lastA = rExpA;
        lastB = rExpB;
        @(posedge clk);
        mA = nA;
        mB = nB;
        #1;
    endtask

    // Producers keep an unaccepted beat stable; otherwise they pick fresh traffic.
    task automatic applyStimulus();
        for (int c = 0; c < 4; c++) begin
            if (!busA.inValid[c] || lastA[c]) begin
                busA.inValid[c]       = 1'($urandom_range(0, 1));
                busA.inData[c*8 +: 8] = 8'($urandom);
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (!busB.inValid[c] || lastB[c]) begin
                busB.inValid[c]       = 1'($urandom_range(0, 1));
                busB.inData[c*8 +: 8] = 8'($urandom);
            end
        end
        busA.outReady = ($urandom_range(0, 3) != 0);
        busB.outReady = ($urandom_range(0, 3) != 0);
        rst           = ($urandom_range(0, 59) == 0);
    endtask

    initial begin
        lastA         = '0;
        lastB         = '0;
        rst           = 1'b1;
        busA.inValid  = 4'hF;
        busA.inData   = 32'h0;
        busA.outReady = 1'b1;
        busB.inValid  = 3'b000;
        busB.inData   = 24'h0;
        busB.outReady = 1'b1;
        @(posedge clk);
        #1;
        mA = '0;
        mB = '0;
        $display("[TB] reset with requests pending");
        cycle();

        $display("[TB] reset in the middle of traffic");
        rst           = 1'b0;
        busA.inValid  = 4'b0001;
        busA.inData   = 32'h0000_005A;
        busA.outReady = 1'b0;
        cycle();
        check("t1_loaded_valid", 32'(busA.outValid), 32'd1);
        check("t1_loaded_data",  32'(busA.outData),  32'h5A);
        busA.inValid = 4'b0000;
        cycle();
        rst           = 1'b1;
        busA.inValid  = 4'hF;
        busA.outReady = 1'b1;
        cycle();
        check("t1_rst_valid", 32'(busA.outValid), 32'd0);
        check("t1_rst_data",  32'(busA.outData),  32'd0);
        check("t1_rst_src",   32'(busA.outSrc),   32'd0);
        rst         = 1'b0;
        busA.inData = 32'h1312_1110;
        cycle();
        check("t1_first_src", 32'(busA.outSrc), 32'd0);

        $display("[TB] full contention");
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t2_src",   32'(busA.outSrc),   32'((i + 1) % 4));
            check("t2_data",  32'(busA.outData),  32'(8'h10 + (i + 1) % 4));
            check("t2_valid", 32'(busA.outValid), 32'd1);
        end

        $display("[TB] wrap and skip");
        busA.inValid = 4'b0100;
        busA.inData  = 32'h0022_0000;
        cycle();
        check("t3_setup_src", 32'(busA.outSrc), 32'd2);
        busA.inValid = 4'b0101;
        busA.inData  = 32'h0022_0000;
        cycle();
        check("t3_wrap_src", 32'(busA.outSrc), 32'd0);
        cycle();
        check("t3_next_src", 32'(busA.outSrc), 32'd2);
        cycle();
        check("t3_back_src", 32'(busA.outSrc), 32'd0);

        $display("[TB] backpressure");
        busA.outReady = 1'b0;
        busA.inValid  = 4'b0010;
        busA.inData   = 32'h0000_7700;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4_hold_src",   32'(busA.outSrc),   32'd0);
            check("t4_hold_valid", 32'(busA.outValid), 32'd1);
        end
        busA.outReady = 1'b1;
        cycle();
        check("t4_release_src",  32'(busA.outSrc),  32'd1);
        check("t4_release_data", 32'(busA.outData), 32'h77);

        $display("[TB] drain");
        busA.inValid = 4'b0100;
        busA.inData  = 32'h00C3_0000;
        cycle();
        check("t5_beat_valid", 32'(busA.outValid), 32'd1);
        check("t5_beat_data",  32'(busA.outData),  32'hC3);
        busA.inValid = 4'b0000;
        cycle();
        check("t5_drain_valid", 32'(busA.outValid), 32'd0);
        check("t5_drain_data",  32'(busA.outData),  32'hC3);
        cycle();
        check("t5_idle_valid", 32'(busA.outValid), 32'd0);

        $display("[TB] three-channel contention");
        busB.inValid = 3'b111;
        busB.inData  = 24'h22_2120;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t6_src", 32'(busB.outSrc), 32'(i % 3));
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus();
            cycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
